// File: rtl/write_master.sv
// AXI4 write master: drains an FWFT FIFO to a destination address as a
// series of INCR bursts. Bursts are capped at MAX_BURST_BEATS, never cross
// a 4 KB page, and each B response is collected before the next AW goes out.
module write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST_BEATS    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start,
  input  logic [31:0]                       i_dst_addr,
  input  logic [31:0]                       i_total_len,
  output logic                              o_write_done,
  output logic                              o_busy,
  output logic                              o_write_error,
  input  logic                              i_fifo_empty,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_fifo_data,
  output logic                              o_fifo_pop,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                          r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [29:0]                     r_words;
  logic [8:0]                      r_beats;
  logic [8:0]                      r_beat_cnt;
  logic                            r_awvalid;
  logic                            r_done;
  logic                            r_err;

  logic [12:0]                     w_room_bytes;
  logic [31:0]                     w_min;
  logic [8:0]                      w_beats;
  logic [8:0]                      w_len9;
  logic                            w_wvalid;
  logic                            w_wlast;
  logic [9:0]                      w_unused;

  // Bytes left before the next 4 KB page; address is word aligned so >>2 is exact.
  assign w_room_bytes = 13'h1000 - {1'b0, r_addr[11:0]};

  // Next burst length: smallest of remaining words, burst cap and page room.
  always_comb begin
    w_min = 32'(MAX_BURST_BEATS);
    if ({2'b00, r_words} < w_min) w_min = {2'b00, r_words};
    if ({21'b0, w_room_bytes[12:2]} < w_min) w_min = {21'b0, w_room_bytes[12:2]};
  end

  assign w_beats  = w_min[8:0];
  assign w_len9   = w_beats - 9'd1;
  assign w_unused = {w_min[31:25], w_len9[8], i_total_len[1:0]};

  assign w_wvalid = (r_state == S_DATA) && !i_fifo_empty;
  assign w_wlast  = (r_beat_cnt == r_beats - 9'd1);

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = w_len9[7:0];
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = i_fifo_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_wlast;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_bready  = (r_state == S_RESP);
  assign o_fifo_pop    = w_wvalid && m_axi_wready;
  assign o_busy        = (r_state != S_IDLE);
  assign o_write_done  = r_done;
  assign o_write_error = r_err;

  // Transfer sequencer: address phase, data beats, response, repeat until no words remain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_words    <= '0;
      r_beats    <= '0;
      r_beat_cnt <= '0;
      r_awvalid  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr  <= C_M_AXI_ADDR_WIDTH'(i_dst_addr);
            r_words <= i_total_len[31:2];
            r_err   <= 1'b0;
            if (i_total_len[31:2] == 30'd0) begin
              r_done <= 1'b1;
            end else begin
              r_done    <= 1'b0;
              r_awvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_beats    <= w_beats;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wvalid && m_axi_wready) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_wlast) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) r_err <= 1'b1;
            r_addr  <= r_addr + C_M_AXI_ADDR_WIDTH'({r_beats, 2'b00});
            r_words <= r_words - {21'b0, r_beats};
            if (r_words == {21'b0, r_beats}) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_awvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_master.sv
// Randomized bench for write_master: an FWFT FIFO model and an AXI slave
// driven from $urandom, with bursts/data/flags compared to a burst-plan model.
module tb_write_master;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dst_addr = '0;
  logic [31:0] i_total_len = '0;
  logic        o_write_done, o_busy, o_write_error;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = '0;
  logic        o_fifo_pop;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  write_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .MAX_BURST_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_dst_addr(i_dst_addr),
    .i_total_len(i_total_len), .o_write_done(o_write_done), .o_busy(o_busy),
    .o_write_error(o_write_error), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
    .o_fifo_pop(o_fifo_pop), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // environment knobs
  int g_rdy_pct = 100, g_empty_pct = 0, g_aw_dly = 0, g_stall_at = -1, g_stall_len = 0, g_err_burst = -1;
  bit start_req = 0;

  // environment state and logs
  logic [31:0] fifo_q[$];
  logic [31:0] aw_addr_q[$];
  int          aw_len_q[$];
  logic [31:0] w_data_q[$];
  bit          w_last_q[$];
  int  pop_cnt, b_cnt, pend_b, aw_cnt, stall_rem, wcnt, done_busy;
  bit  pend_pop, bv, stall_done;
  bit  prev_aw_wait, prev_w_wait;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [7:0]  prev_awlen;

  task automatic clear_env();
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
    pop_cnt = 0; b_cnt = 0; pend_b = 0; aw_cnt = 0; stall_rem = 0; wcnt = 0; done_busy = 0;
    pend_pop = 0; bv = 0; stall_done = 0; prev_aw_wait = 0; prev_w_wait = 0;
  endtask

  // One clock: drive at negedge, sample handshakes that the next posedge will take.
  task automatic cycle();
    bit forced;
    @(negedge clk);
    if (pend_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 0;
    end
    if (g_stall_at >= 0 && !stall_done && wcnt == g_stall_at) begin
      stall_rem = g_stall_len; stall_done = 1;
    end
    forced = (stall_rem > 0);
    if (forced) stall_rem--;
    i_start       = start_req;
    i_fifo_empty  = forced || (fifo_q.size() == 0) || ($urandom_range(99) < g_empty_pct);
    i_fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    m_axi_awready = (aw_cnt >= g_aw_dly) && ($urandom_range(99) < g_rdy_pct);
    m_axi_wready  = ($urandom_range(99) < g_rdy_pct);
    if (!bv && pend_b > 0 && ($urandom_range(99) < g_rdy_pct)) bv = 1;
    m_axi_bvalid  = bv;
    m_axi_bresp   = (bv && b_cnt == g_err_burst) ? 2'b10 : 2'b00;
    #1;
    if (prev_aw_wait) begin
      chk("aw_hold_valid", m_axi_awvalid, 1);
      chk("aw_hold_addr", m_axi_awaddr, prev_awaddr);
      chk("aw_hold_len", m_axi_awlen, prev_awlen);
    end
    if (prev_w_wait && !i_fifo_empty) begin
      chk("w_hold_valid", m_axi_wvalid, 1);
      chk("w_hold_data", m_axi_wdata, prev_wdata);
    end
    if (m_axi_wvalid && i_fifo_empty) chk("wvalid_while_empty", 1, 0);
    if (o_fifo_pop != (m_axi_wvalid && m_axi_wready)) chk("pop_vs_w_hs", o_fifo_pop, !o_fifo_pop);
    if (o_write_done && o_busy) done_busy++;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_addr_q.push_back(m_axi_awaddr);
      aw_len_q.push_back(int'(m_axi_awlen));
      chk("awsize_awburst", {m_axi_awsize, m_axi_awburst}, {3'b010, 2'b01});
      aw_cnt = 0;
    end else if (m_axi_awvalid) aw_cnt++;
    if (m_axi_wvalid && m_axi_wready) begin
      w_data_q.push_back(m_axi_wdata);
      w_last_q.push_back(m_axi_wlast);
      if (m_axi_wstrb != 4'hF) chk("wstrb", m_axi_wstrb, 4'hF);
      wcnt++;
      if (m_axi_wlast) pend_b++;
    end
    if (bv && m_axi_bready) begin
      bv = 0; pend_b--; b_cnt++;
    end
    if (o_fifo_pop) pop_cnt++;
    pend_pop     = o_fifo_pop;
    prev_aw_wait = m_axi_awvalid && !m_axi_awready;
    prev_awaddr  = m_axi_awaddr;
    prev_awlen   = m_axi_awlen;
    prev_w_wait  = m_axi_wvalid && !m_axi_wready;
    prev_wdata   = m_axi_wdata;
  endtask

  // Full transfer: fill FIFO, start, wait for done, compare against burst plan.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input bit seq);
    logic [31:0] exp_data[$];
    logic [31:0] exp_a[$];
    int          exp_l[$];
    logic [31:0] a;
    int w, words, room, b, nb, k, to;
    bit exp_err;
    clear_env();
    fifo_q.delete();
    words = int'(len >> 2);
    for (int i = 0; i < words; i++) begin
      fifo_q.push_back(seq ? 32'(i) : $urandom);
      exp_data.push_back(fifo_q[i]);
    end
    i_dst_addr = addr; i_total_len = len;
    start_req = 1;
    cycle();
    start_req = 0;
    cycle();
    chk("done_after_start", o_write_done, (words == 0));
    chk("err_after_start", o_write_error, 0);
    to = 0;
    while (!o_write_done && to < 5000) begin cycle(); to++; end
    if (to >= 5000) chk("done_timeout", 0, 1);
    if (words == 0) repeat (3) cycle();
    // burst plan
    a = addr; w = words;
    while (w > 0) begin
      room = (4096 - int'(a & 32'hFFF)) / 4;
      b = w; if (MAXB < b) b = MAXB; if (room < b) b = room;
      exp_a.push_back(a); exp_l.push_back(b);
      a = a + 32'(b * 4); w -= b;
    end
    nb = exp_a.size();
    exp_err = (g_err_burst >= 0) && (g_err_burst < nb);
    chk("busy_at_end", o_busy, 0);
    chk("done_while_busy", done_busy, 0);
    chk("error_flag", o_write_error, exp_err);
    chk("burst_count", aw_addr_q.size(), nb);
    chk("beat_count", w_data_q.size(), words);
    chk("pop_count", pop_cnt, words);
    if (aw_addr_q.size() == nb)
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("awaddr[%0d]", i), aw_addr_q[i], exp_a[i]);
        chk($sformatf("awlen[%0d]", i), aw_len_q[i], exp_l[i] - 1);
      end
    if (w_data_q.size() == words) begin
      k = 0;
      for (int i = 0; i < nb; i++)
        for (int j = 0; j < exp_l[i]; j++) begin
          chk($sformatf("wdata[%0d]", k), w_data_q[k], exp_data[k]);
          chk($sformatf("wlast[%0d]", k), w_last_q[k], (j == exp_l[i] - 1));
          k++;
        end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                          o_write_done, o_write_error, o_busy}, 0);
    reset = 0;

    // single full burst, sequential data, always ready
    run_xfer(32'h0000_0000, 64, 1);
    // multi-burst with short tail
    run_xfer(32'h0000_1000, 200, 0);
    // 4 KB page split
    run_xfer(32'h0000_0FF8, 32, 0);
    // delayed awready, FIFO gap mid-burst
    g_aw_dly = 3; g_stall_at = 5; g_stall_len = 5;
    run_xfer(32'h0000_2000, 64, 1);
    g_aw_dly = 0; g_stall_at = -1;
    // error response on first burst, transfer still completes
    g_err_burst = 0; g_rdy_pct = 70; g_empty_pct = 20;
    run_xfer(32'h0000_3000, 128, 0);
    g_err_burst = -1;
    // address wrap at top of memory
    run_xfer(32'hFFFF_FFF0, 40, 0);
    // zero words
    g_rdy_pct = 100; g_empty_pct = 0;
    run_xfer(32'h0000_0100, 3, 0);
    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      g_rdy_pct   = 40 + $urandom_range(60);
      g_empty_pct = $urandom_range(30);
      g_err_burst = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1;
      run_xfer({20'($urandom), 10'($urandom), 2'b00} | (($urandom_range(1) == 1) ? 32'h0000_0FC0 : 32'h0),
               32'($urandom_range(400)), 0);
    end
    g_err_burst = -1; g_rdy_pct = 100; g_empty_pct = 0;

    // reset in the middle of DATA
    begin
      int to;
      clear_env(); fifo_q.delete();
      for (int i = 0; i < 64; i++) fifo_q.push_back(32'(i));
      g_rdy_pct = 50;
      i_dst_addr = 32'h0000_4000; i_total_len = 256;
      start_req = 1; cycle(); start_req = 0;
      to = 0;
      while (!(o_busy && !m_axi_awvalid && !m_axi_bready && wcnt >= 3) && to < 200) begin cycle(); to++; end
      chk("reach_data_phase", (to < 200), 1);
      reset = 1;
      #1;
      chk("reset_mid_data", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                             o_write_done, o_write_error, o_busy}, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      clear_env(); fifo_q.delete();
      g_rdy_pct = 100;
      run_xfer(32'h0000_5000, 20, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/write_master.md
Name: write_master

Overview:
- AXI4-Full write master; the DMA stage directly downstream of the read master's data FIFO.
- Pops 32-bit words from a first-word-fall-through FIFO and writes them to a destination address as INCR bursts.
- Splits each transfer into bursts of at most MAX_BURST_BEATS beats; no burst crosses a 4 KB boundary.
- Completes each burst's B handshake before issuing the next AW.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
MAX_BURST_BEATS, 16, maximum beats per burst (1..256)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_start  in  1  start request, sampled in IDLE only
i_dst_addr  in  32  destination byte address (word aligned)
i_total_len  in  32  byte count; bits [1:0] ignored
o_write_done  out  1  level; set when transfer completes, cleared on next accepted i_start
o_busy  out  1  high whenever state != IDLE
o_write_error  out  1  sticky; set on any BRESP != OKAY, cleared on accepted i_start
i_fifo_empty  in  1  FIFO empty
i_fifo_data  in  32  FIFO head word (FWFT)
o_fifo_pop  out  1  pop FIFO head
m_axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR/8/3/2/1  AW channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  32/4/1/1  W channel
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0 (awvalid, wvalid, bready, o_fifo_pop, done, error, busy).
- Reset asserted mid-transfer aborts immediately; no completion of outstanding AXI bursts is attempted.
- States: IDLE, ADDR, DATA, RESP.
- IDLE, on i_start:
  - Latch addr = i_dst_addr and words = i_total_len[31:2].
  - Clear o_write_done and o_write_error.
  - If words == 0: set o_write_done next cycle and stay in IDLE; no AXI traffic.
  - Otherwise go to ADDR with awvalid registered high on entry.
- i_start outside IDLE is ignored.
- Burst sizing: beats = min(words, MAX_BURST_BEATS, (0x1000 - addr[11:0]) >> 2).
  - awlen = beats - 1; awaddr = addr.
  - awsize = 3'b010; awburst = 2'b01.
  - beats is latched into a burst register at the AW handshake.
- ADDR:
  - awvalid is held high, with AW fields stable, until awready is seen.
  - On handshake, awvalid drops the next cycle; the beat counter clears; go to DATA.
- DATA:
  - wvalid = (state == DATA) && !i_fifo_empty; this is combinational.
  - wdata = i_fifo_data; wstrb = 4'hF.
  - o_fifo_pop = wvalid && wready.
  - wlast = (beat_cnt == beats - 1).
  - beat_cnt increments on each W handshake.
  - The handshake carrying wlast moves to RESP.
  - An empty FIFO stalls W with no timeout. wvalid may drop between beats only because the FIFO is empty; once asserted it is never withdrawn while wready is low and the FIFO is non-empty.
- RESP:
  - bready = 1.
  - On bvalid: if bresp != 2'b00, set o_write_error.
  - Then addr += beats*4; words -= beats.
  - If words == 0: go to IDLE and set o_write_done.
  - Otherwise go to ADDR with awvalid high on entry.
  - Error does not abort the transfer.
- Arithmetic: 32-bit unsigned.
  - A word count not a multiple of the burst size yields a short final burst.
  - Address wraps modulo 2^32; the 4 KB rule guarantees no burst straddles the wrap.
- Simultaneous events:
  - bvalid arriving in the same cycle RESP is entered is accepted that cycle.
  - awready already high on ADDR entry completes the handshake in the first ADDR cycle.
- Minimum per-burst overhead: 1 ADDR cycle + beats + 1 RESP cycle.

Test Plan:
- addr 0x0000_0000, len 64, FIFO full of 0..15, ready/bvalid always high -> one AW (awlen 15); 16 W beats in order with wlast on beat 16; o_write_done=1 after B; 16 pops.
- addr 0x0000_1000, len 200 -> awlen sequence 15,15,15,1 at addrs 0x1000,0x1040,0x1080,0x10C0; total 50 pops; done set once.
- addr 0x0000_0FF8, len 32 -> burst 1 awlen 1 at 0x0FF8, burst 2 awlen 5 at 0x1000; no 4 KB crossing.
- FIFO empty for 5 cycles mid-burst, awready delayed 3 cycles -> wvalid low while empty; AW fields stable while waiting; beat order and count unchanged.
- BRESP=2'b10 on first of two bursts -> o_write_error=1 and second burst still issued; error cleared by next i_start.
- len 3 (zero words) -> no awvalid ever; o_write_done=1 one cycle after i_start; reset asserted mid-DATA -> all outputs 0 immediately, state IDLE.
